// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX byte stream among
// NUM_REQ producers, with a one-entry registered output stage.

module uart_tx_arb_lane (
  input  logic       sel,
  input  logic       locked,
  input  logic       load_ok,
  input  logic       valid,
  input  logic       last,
  input  logic [7:0] data,
  output logic       ready,
  output logic       xfer,
  output logic       xfer_last,
  output logic [7:0] data_sel
);
  assign ready     = locked & sel & load_ok;
  assign xfer      = valid & ready;
  assign xfer_last = xfer & last;
  assign data_sel  = sel ? data : 8'h00;
endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 64,
  parameter int ID_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           to_uart_data,
  output logic                 to_uart_error,
  output logic                 to_uart_valid,
  input  logic                 to_uart_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                    state;
  logic [ID_W-1:0]           rr_ptr;
  logic [7:0]                burst_cnt;
  logic                      load_ok;
  logic                      locked;
  logic [NUM_REQ-1:0]        lane_sel;
  logic [NUM_REQ-1:0]        lane_xfer;
  logic [NUM_REQ-1:0]        lane_last;
  logic [NUM_REQ-1:0][7:0]   lane_din;
  logic [NUM_REQ-1:0][7:0]   lane_dsel;
  logic                      in_xfer;
  logic                      in_last;
  logic                      rel;
  logic [7:0]                g_data;
  logic [ID_W-1:0]           winner;
  logic                      found;

  assign load_ok       = !to_uart_valid || to_uart_ready;
  assign locked        = (state == LOCKED);
  assign lane_din      = req_data;
  assign to_uart_error = 1'b0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_sel[i] = (grant_id == ID_W'(i));
    uart_tx_arb_lane u_lane (
      .sel       (lane_sel[i]),
      .locked    (locked),
      .load_ok   (load_ok),
      .valid     (req_valid[i]),
      .last      (req_last[i]),
      .data      (lane_din[i]),
      .ready     (req_ready[i]),
      .xfer      (lane_xfer[i]),
      .xfer_last (lane_last[i]),
      .data_sel  (lane_dsel[i])
    );
  end

  assign in_xfer = |lane_xfer;
  assign in_last = |lane_last;
  // Burst cap counts the byte being accepted now, so compare against MAX_BURST-1.
  assign rel     = in_xfer && (in_last || burst_cnt == 8'(MAX_BURST - 1));

  always_comb begin
    g_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) g_data = g_data | lane_dsel[i];
  end

  // Outer loop is the search distance from rr_ptr, so the nearest valid wins.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] &&
            (int'(rr_ptr) + k == j || int'(rr_ptr) + k == j + NUM_REQ)) begin
          winner = ID_W'(j);
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      to_uart_valid <= 1'b0;
      to_uart_data  <= 8'h00;
      grant_id      <= '0;
      busy          <= 1'b0;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      burst_cnt     <= 8'h00;
    end else begin
      if (in_xfer) begin
        to_uart_data  <= g_data;
        to_uart_valid <= 1'b1;
      end else if (to_uart_ready) begin
        to_uart_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= winner;
            burst_cnt <= 8'h00;
            state     <= LOCKED;
            busy      <= 1'b1;
          end
        end
        LOCKED: begin
          if (rel) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rr_ptr    <= grant_id;
            burst_cnt <= 8'h00;
          end else if (in_xfer) begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester source queues feed the DUT,
// expected UART bytes are queued at stimulus time and popped on each output transfer.

module tb_uart_tx_arbiter;
  localparam int NR = 3;

  logic          clk;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [7:0]    to_uart_data;
  logic          to_uart_error;
  logic          to_uart_valid;
  logic          to_uart_ready;
  logic [1:0]    grant_id;
  logic          busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4), .ID_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .to_uart_data  (to_uart_data),
    .to_uart_error (to_uart_error),
    .to_uart_valid (to_uart_valid),
    .to_uart_ready (to_uart_ready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  logic [8:0]    src [NR][$];
  logic [7:0]    exp_q[$];
  logic [NR-1:0] hold;
  int            acc_cnt [NR];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            last_out = 0;
  int            prev_out = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic last);
    src[id].push_back({last, d});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NR; i++) if (src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic flush();
    for (int i = 0; i < NR; i++) begin
      src[i].delete();
      acc_cnt[i] = 0;
    end
    exp_q.delete();
    hold = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    flush();
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !srcs_empty()) && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, (n < budget), 1);
    step(3);
  endtask

  // Driver + monitor: sample handshakes mid-cycle, apply them after the edge.
  initial begin
    logic [NR-1:0] hs, hs_last;
    logic          out_hs;
    logic [7:0]    dsmp;
    forever begin
      @(negedge clk);
      hs      = reset ? (req_valid & req_ready) : '0;
      hs_last = hs & req_last;
      out_hs  = reset && to_uart_valid && to_uart_ready;
      dsmp    = to_uart_data;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NR; i++)
        if (hs[i] && src[i].size() != 0) begin
          void'(src[i].pop_front());
          acc_cnt[i]++;
        end
      if (out_hs) begin
        if (exp_q.size() == 0) chk("out_extra", exp_q.size(), 1);
        else begin
          chk("out_byte", dsmp, exp_q.pop_front());
          prev_out = last_out;
          last_out = cyc;
        end
      end
      if (|hs_last) chk("busy_after_last", busy, 0);
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (src[i].size() != 0) && !hold[i];
        if (src[i].size() != 0) begin
          req_data[i*8 +: 8] = src[i][0][7:0];
          req_last[i]        = src[i][0][8];
        end else begin
          req_data[i*8 +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; to_uart_ready = 1'b0; hold = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    flush();
    step(3);
    chk("rst_valid", to_uart_valid, 0);
    chk("rst_data", to_uart_data, 8'h00);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_error", to_uart_error, 0);

    // Quiet after reset release, then a two-byte message from requester 0.
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk("idle_quiet", {to_uart_valid, req_ready, busy}, 0);
    end
    to_uart_ready = 1'b1;
    push(0, 8'h41, 1'b0); exp_q.push_back(8'h41);
    push(0, 8'h42, 1'b1); exp_q.push_back(8'h42);
    wait_drain("t1_drain", 50);
    chk("t1_gap", last_out - prev_out, 1);
    chk("t1_busy", busy, 0);
    chk("t1_valid", to_uart_valid, 0);

    // Fairness: all three stream two 4-byte messages each.
    apply_reset();
    to_uart_ready = 1'b1;
    for (int m = 0; m < 2; m++)
      for (int id = 0; id < NR; id++)
        for (int b = 0; b < 4; b++) begin
          push(id, {2'(id), 2'(m), 4'(b)}, b == 3);
          exp_q.push_back({2'(id), 2'(m), 4'(b)});
        end
    wait_drain("fair_drain", 200);

    // Backpressure: 0x55 held in the output stage for 5 cycles.
    apply_reset();
    to_uart_ready = 1'b0;
    push(0, 8'h55, 1'b0); exp_q.push_back(8'h55);
    push(0, 8'h56, 1'b1); exp_q.push_back(8'h56);
    n = 0;
    while (!to_uart_valid && n < 20) begin step(1); n++; end
    chk("bp_load", to_uart_valid, 1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", {to_uart_valid, to_uart_data, req_ready}, {1'b1, 8'h55, 3'b000});
      step(1);
    end
    to_uart_ready = 1'b1;
    wait_drain("bp_drain", 50);

    // Burst cap of 4: requester 1 is forced to yield to waiting requester 2.
    apply_reset();
    to_uart_ready = 1'b1;
    for (int k = 0; k < 10; k++) push(1, 8'h10 + 8'(k), k == 9);
    push(2, 8'h20, 1'b0);
    push(2, 8'h21, 1'b1);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h10 + 8'(k));
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    for (int k = 4; k < 10; k++) exp_q.push_back(8'h10 + 8'(k));
    wait_drain("burst_drain", 200);

    // Reset after 2 of 5 bytes from requester 0.
    apply_reset();
    to_uart_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(0, 8'hA0 + 8'(k), k == 4);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    n = 0;
    while (acc_cnt[0] < 2 && n < 50) begin step(1); n++; end
    chk("mr_progress", acc_cnt[0], 2);
    reset = 1'b0;
    flush();
    step(1);
    chk("mr_valid", to_uart_valid, 0);
    chk("mr_busy", busy, 0);
    reset = 1'b1;
    step(1);
    for (int k = 0; k < 3; k++) begin
      push(2, 8'hC0 + 8'(k), k == 2);
      exp_q.push_back(8'hC0 + 8'(k));
    end
    n = 0;
    while (!busy && n < 20) begin step(1); n++; end
    chk("mr_grant", {busy, grant_id}, {1'b1, 2'd2});
    wait_drain("mr_drain", 50);

    // Owner stall: requester 0 pauses mid-message, requester 1 must wait.
    apply_reset();
    to_uart_ready = 1'b1;
    push(0, 8'hB0, 1'b0); push(0, 8'hB1, 1'b0); push(0, 8'hB2, 1'b1);
    push(1, 8'hD0, 1'b0); push(1, 8'hD1, 1'b1);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hD0); exp_q.push_back(8'hD1);
    n = 0;
    while (acc_cnt[0] < 1 && n < 50) begin step(1); n++; end
    hold[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("stall_grant", {grant_id, busy, req_ready[1]}, {2'd0, 1'b1, 1'b0});
    end
    hold[0] = 1'b0;
    wait_drain("stall_drain", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit stream (to_uart_data / to_uart_valid / to_uart_ready) between NUM_REQ independent byte producers, e.g. CPU console port, debug monitor and exception dumper.
- Arbitration is round-robin at message granularity: a grant is held until the owner sends a byte flagged last, or until MAX_BURST bytes have been sent.
- A one-entry registered output stage decouples requester timing from the UART.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_BURST, 64, maximum bytes per grant before forced release (1..255)
ID_W, 2, width of grant_id; must satisfy 2^ID_W >= NUM_REQ

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  byte is the final byte of the message
req_ready  output  NUM_REQ  per-requester accept
to_uart_data  output  8  byte to UART TX
to_uart_error  output  1  tied 0
to_uart_valid  output  1  output stage holds a byte
to_uart_ready  input  1  UART accepts byte
grant_id  output  ID_W  current or most recent owner
busy  output  1  1 while in LOCKED

Behaviour:
- One clock; reset is synchronous and active-low. It is sampled on the clk rising edge while low.
- Reset values:
  - state = IDLE
  - req_ready = 0
  - to_uart_valid = 0, to_uart_data = 0x00
  - grant_id = 0, busy = 0
  - rr_ptr = NUM_REQ-1, so requester 0 has priority first
  - burst_cnt = 0
- Reset mid-message discards the output-stage byte and drops the grant immediately. No partial handshake survives reset.
- Definitions:
  - load_ok = !to_uart_valid || to_uart_ready.
  - Output transfer = to_uart_valid && to_uart_ready.
  - Input transfer = req_valid[g] && req_ready[g], where g = grant_id.
- State IDLE:
  - req_ready = 0.
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr+1 with wrap-around modulo NUM_REQ.
  - Register grant_id = winner, burst_cnt = 0, go to LOCKED. The grant is visible the next cycle.
  - If no req_valid is set, stay in IDLE.
- State LOCKED:
  - req_ready[g] = load_ok; all other req_ready bits are 0. req_ready is combinational from to_uart_ready and state.
  - On input transfer: to_uart_data <= byte, to_uart_valid <= 1, burst_cnt += 1.
  - On an output transfer with no input transfer: to_uart_valid <= 0.
  - A simultaneous output and input transfer keeps to_uart_valid = 1 with the new byte. This gives full throughput of one byte per cycle.
  - Release happens on an input transfer with req_last[g] = 1, or with burst_cnt+1 == MAX_BURST. On release: go to IDLE, rr_ptr <= g, burst_cnt <= 0.
  - The byte already in the output stage still drains normally after release.
  - A granted requester deasserting req_valid mid-message keeps the grant. There is no timeout.
- Latency:
  - Request to grant: 1 cycle.
  - Input transfer to to_uart_valid: 1 cycle.
  - Minimum gap between messages from different owners: 1 IDLE cycle, with no bubble on the UART if to_uart_ready is held low.
- Output data stability: to_uart_data and to_uart_valid hold stable while to_uart_valid=1 and to_uart_ready=0. This follows from load_ok=0.
- busy = (state == LOCKED). grant_id holds its last value in IDLE.
- to_uart_error is constant 0.
- Requesters must hold req_data and req_last stable while req_valid=1 and req_ready=0. The arbiter never samples unaccepted data.

Test Plan:
- Reset release with no requests: to_uart_valid=0, req_ready=000, busy=0 for 20 cycles. Then req_valid=001 with bytes 0x41,0x42 (last on 0x42) and to_uart_ready=1: the UART receives 0x41,0x42 on consecutive cycles, and busy drops the cycle after 0x42 is accepted.
- Fairness: all three requesters send 4-byte messages continuously. Owner order is 0,1,2,0,1,2 and no byte from one message interleaves with another.
- Backpressure: to_uart_ready=0 for 5 cycles with byte 0x55 pending. to_uart_data stays 0x55, req_ready[g]=0, and no byte is lost or duplicated after ready returns.
- Burst cap: MAX_BURST=4, requester 1 streams 10 bytes with last only on byte 10 while requester 2 is waiting. The UART sees 4 bytes from 1, then a message from 2, then requester 1 resumes.
- Reset mid-message: assert reset low after 2 of 5 bytes from requester 0. Next cycle to_uart_valid=0 and busy=0. After release, a new request from requester 2 is granted first-come and byte order is correct.
- Owner stall: granted requester 0 drops req_valid for 10 cycles mid-message while requester 1 is valid. The grant stays 0 and req_ready[1] stays 0 until requester 0 sends its last byte.
